// File: rtl/serial_add_sequencer_pkg.sv
// Shared definitions for the serial add sequencer: state encoding and default width.
package serial_add_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLR   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    localparam int DEFAULT_N = 8;

endpackage

// File: rtl/serial_add_sequencer_piso.sv
// Parallel-in serial-out shift register: parallel load, right shift, LSB presented on bit_o.
module piso_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] din_i,
    output logic         bit_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= din_i;
        end else if (shift_i) begin
            data_q <= {1'b0, data_q[W-1:1]};
        end
    end

    assign bit_o = data_q[0];

endmodule

// File: rtl/serial_add_sequencer.sv
// Feeds operand pairs LSB-first to an external Mealy serial adder and reassembles the sum.
//
// state | meaning
// IDLE  | waiting for an operand pair (in_ready=1)
// CLR   | one cycle clearing the adder's carry (add_clr=1)
// SHIFT | N cycles presenting operand bits and capturing sum_bit
// DONE  | result valid, held until out_ready
module serial_add_sequencer
    import serial_add_sequencer_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic         a_bit,
    output logic         b_bit,
    output logic         add_clr,
    input  logic         sum_bit,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result
);

    localparam int CW = $clog2(N);

    seq_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  result_q, result_d;
    logic          load, shift;
    logic          a_lsb, b_lsb;

    piso_shift_reg #(.W(N)) u_piso_a (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .shift_i (shift),
        .din_i   (op_a),
        .bit_o   (a_lsb)
    );

    piso_shift_reg #(.W(N)) u_piso_b (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .shift_i (shift),
        .din_i   (op_b),
        .bit_o   (b_lsb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        load      = 1'b0;
        shift     = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        a_bit     = 1'b0;
        b_bit     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = CLR;
                end
            end
            CLR: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                a_bit    = a_lsb;
                b_bit    = b_lsb;
                shift    = 1'b1;
                // Sum bits enter at the MSB so bit i settles in result[i] after N shifts.
                result_d = {sum_bit, result_q[N-1:1]};
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset also clears the external adder's carry across the reset edge.
    assign add_clr = rst | (state_q == CLR);
    assign result  = result_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench: serial_add_sequencer driving a behavioural Mealy serial adder.
module tb_serial_add_sequencer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         a_bit;
    logic         b_bit;
    logic         add_clr;
    logic         sum_bit;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_add_sequencer #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .add_clr   (add_clr),
        .sum_bit   (sum_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    // External Mealy serial adder: carry register with synchronous clear.
    logic carry_q;
    always_ff @(posedge clk) begin
        if (add_clr) carry_q <= 1'b0;
        else         carry_q <= (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
    end
    assign sum_bit = a_bit ^ b_bit ^ carry_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("wait_in_ready_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input int hold, input bit jitter);
        logic [N-1:0] exp;
        int idx;
        int clr_cnt;
        bit seen;
        exp = N'((int'(a) + int'(b)) % (1 << N));
        wait_ready();
        op_a      = a;
        op_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        idx = 0; clr_cnt = 0; seen = 0;
        while (!seen && idx < 40) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
            end else begin
                if (add_clr) clr_cnt++;
                if (idx == 0) begin
                    check("clr_a_bit", a_bit, 0);
                    check("clr_b_bit", b_bit, 0);
                end else if (idx <= N) begin
                    check("shift_a_bit", a_bit, a[idx-1]);
                    check("shift_b_bit", b_bit, b[idx-1]);
                end
                check("busy_in_ready", in_ready, 0);
                idx++;
            end
            if (jitter) begin
                in_valid = 1'b1;
                op_a     = N'($urandom);
                op_b     = N'($urandom);
            end else begin
                in_valid = 1'b0;
            end
        end
        check("latency", idx, N + 1);
        check("result", result, exp);
        check("clr_pulses", clr_cnt, 1);
        check("done_a_bit", a_bit, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_result", result, exp);
            check("hold_in_ready", in_ready, 0);
            check("hold_add_clr", add_clr, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
        check("idle_result", result, exp);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_add_clr", add_clr, 1);
        check("rst_result", result, 0);
        check("rst_a_bit", a_bit, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_add_clr", add_clr, 0);

        do_op(8'd3, 8'd5, 0, 0);
        do_op(8'hFF, 8'h01, 0, 0);
        do_op(8'hAA, 8'h55, 0, 0);
        do_op(8'h80, 8'h80, 5, 0);
        do_op(8'h21, 8'h42, 2, 1);

        // Reset while bit 3 of 0x0F+0x01 is on the adder inputs.
        wait_ready();
        op_a = 8'h0F; op_b = 8'h01; in_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        check("pre_rst_a_bit", a_bit, 1);
        rst = 1'b1;
        #1;
        check("midrst_add_clr", add_clr, 1);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_result", result, 0);
        check("midrst_a_bit", a_bit, 0);
        @(posedge clk);
        @(negedge clk);
        check("midrst_add_clr2", add_clr, 1);
        rst = 1'b0;
        #1;
        check("after_rst_in_ready", in_ready, 1);
        check("after_rst_add_clr", add_clr, 0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("abandon_no_valid", out_valid, 0);
        end
        do_op(8'h12, 8'h34, 1, 0);

        for (int k = 0; k < 8; k++) begin
            do_op(N'($urandom), N'($urandom), int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_add_sequencer.md
SERIAL_ADD_SEQUENCER -- requirements
Module: serial_add_sequencer

Interface
REQ-001 Parameter: N, default 8, operand/result width in bits (N >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 op_a  input  N  operand A, unsigned.
REQ-007 op_b  input  N  operand B, unsigned.
REQ-008 a_bit  output  1  serial A bit to the downstream Mealy serial adder, LSB first.
REQ-009 b_bit  output  1  serial B bit to the adder, LSB first.
REQ-010 add_clr  output  1  drives the adder's synchronous reset (carry state clear).
REQ-011 sum_bit  input  1  combinational sum bit returned by the adder in the same cycle.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 result  output  N  (op_a + op_b) mod 2^N; carry-out is not reported.

Function
REQ-015 FSM states: IDLE, CLR, SHIFT, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; the operand handshake fires on an edge with in_valid & in_ready.
REQ-017 On the handshake edge: load op_a/op_b into internal shift registers, clear the bit counter, IDLE -> CLR.
REQ-018 CLR: lasts exactly one cycle, add_clr=1, a_bit=b_bit=0, then CLR -> SHIFT.
REQ-019 SHIFT: a_bit/b_bit = bit 0 of the A/B shift registers; on each edge, shift both right by one and capture sum_bit into result (shift in at MSB, so bit i lands in result[i] after N shifts).
REQ-020 The bit counter increments per SHIFT edge; SHIFT -> DONE on the edge that captures bit N-1 (exactly N SHIFT cycles).
REQ-021 DONE: out_valid=1, result stable; DONE -> IDLE on an edge with out_ready=1; otherwise hold indefinitely.
REQ-022 Latency: handshake edge E0; result captured at edge E(N+1); out_valid high in the cycle following E(N+1).
REQ-023 Minimum period per operation is N+3 cycles (IDLE, CLR, N x SHIFT, DONE).
REQ-024 Outside SHIFT, a_bit=b_bit=0; outside CLR and reset, add_clr=0.
REQ-025 in_valid asserted outside IDLE SHALL be ignored; op_a/op_b changes after the handshake do not affect the operation in flight.
REQ-026 result SHALL change only during SHIFT; it holds the last result in IDLE until the next operation starts shifting.
REQ-027 Sum wrap-around: the carry out of bit N-1 is discarded (e.g. N=8: 0xFF+0x01 -> 0x00).

Reset
REQ-028 While rst=1: state=IDLE, shift registers, counter and result = 0 immediately (asynchronous).
REQ-029 add_clr SHALL equal rst | (state==CLR), so an asserted reset also clears the adder across an edge.
REQ-030 Reset mid-operation SHALL abandon the operation with no out_valid pulse; in_ready=1 in the first cycle after rst deasserts.

Structure
REQ-031 A shared package SHALL hold the state encoding (2-bit, IDLE=0, CLR=1, SHIFT=2, DONE=3) and the default width constant.
REQ-032 Counter width is clog2(N).
REQ-033 One sub-module is natural: piso_shift_reg (parallel load, right shift, LSB out), instantiated once each for A and B.
REQ-034 The adder itself is not instantiated inside this block; the bench connects the team's Mealy serial adder externally.

Verification
REQ-035 N=8: op_a=3, op_b=5, out_ready=1 -> result=0x08, out_valid at cycle E0+10.
REQ-036 N=8: 0xFF+0x01 -> result=0x00; and 0xAA+0x55 -> 0xFF, with no carry leaking between back-to-back operations.
REQ-037 out_ready low for 5 cycles in DONE -> out_valid and result held stable; in_ready=0 throughout; IDLE on the first out_ready=1 edge.
REQ-038 rst pulsed during SHIFT bit 3 of 0x0F+0x01 -> no out_valid; add_clr=1 during reset; next operation 0x12+0x34 -> 0x46.
REQ-039 in_valid held high with changing op_a/op_b during CLR/SHIFT/DONE -> only the first pair is summed; exactly one add_clr pulse per operation.
